// File: rtl/averager_readout.sv
// averager_readout: streams the accumulated sums out of the averager BRAM as
// one AXI4-Stream frame per start, and latches the n_avg belonging to it.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_READ  | issuing one BRAM read per cycle while FIFO credits remain
// S_DRAIN | all reads issued; waiting for the tlast handshake
module averager_readout #(
   parameter int ADDR_WIDTH   = 7,
   parameter int DATA_WIDTH   = 32,
   parameter int N_AVG_WIDTH  = 10,
   parameter int BRAM_LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  last_addr,
   input  logic [N_AVG_WIDTH-1:0] n_avg,
   output logic                   bram_en,
   output logic [ADDR_WIDTH-1:0]  bram_addr,
   input  logic [DATA_WIDTH-1:0]  bram_rdata,
   output logic [DATA_WIDTH-1:0]  m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic [N_AVG_WIDTH-1:0] n_avg_latched,
   output logic                   busy,
   output logic                   done,
   output logic                   overrun
);

   // FIFO sized so a full BRAM pipeline plus one word held at the head and
   // one being popped never runs out of room at full throughput.
   localparam int DEPTH = BRAM_LATENCY + 2;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int PW    = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW:0]   DEPTH_V  = (CW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_rd_addr;
   logic [ADDR_WIDTH-1:0]   r_last_addr;
   logic [N_AVG_WIDTH-1:0]  r_n_avg;
   logic                    r_done;
   logic                    r_overrun;

   logic [BRAM_LATENCY-1:0] r_pv;
   logic [BRAM_LATENCY-1:0] r_plast;

   logic [DATA_WIDTH-1:0]   r_fifo_data [DEPTH];
   logic [DEPTH-1:0]        r_fifo_last;
   logic [PW-1:0]           r_wptr;
   logic [PW-1:0]           r_rptr;
   logic [CW-1:0]           r_count;

   logic [CW-1:0]           w_inflight;
   logic [CW:0]             w_used;
   logic                    w_issue;
   logic                    w_is_last_rd;
   logic                    w_wr;
   logic                    w_wr_last;
   logic                    w_tvalid;
   logic                    w_head_last;
   logic                    w_pop;

   // Reads in flight: one valid bit per BRAM pipeline stage.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < BRAM_LATENCY; i++) begin
         w_inflight = w_inflight + CW'(r_pv[i]);
      end
   end

   assign w_used       = {1'b0, r_count} + {1'b0, w_inflight};
   assign w_issue      = (r_state == S_READ) && (w_used < DEPTH_V);
   assign w_is_last_rd = (r_rd_addr == r_last_addr);
   assign w_wr         = r_pv[BRAM_LATENCY-1];
   assign w_wr_last    = r_plast[BRAM_LATENCY-1];
   assign w_tvalid     = (r_count != '0);
   assign w_head_last  = r_fifo_last[r_rptr];
   assign w_pop        = w_tvalid && m_axis_tready;

   assign bram_en       = w_issue;
   assign bram_addr     = w_issue ? r_rd_addr : '0;
   assign m_axis_tvalid = w_tvalid;
   assign m_axis_tdata  = w_tvalid ? r_fifo_data[r_rptr] : '0;
   assign m_axis_tlast  = w_tvalid && w_head_last;
   assign n_avg_latched = r_n_avg;
   assign busy          = (r_state != S_IDLE);
   assign done          = r_done;
   assign overrun       = r_overrun;

   // Frame sequencing: start acceptance, read address walk, done and overrun.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_rd_addr   <= '0;
         r_last_addr <= '0;
         r_n_avg     <= '0;
         r_done      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_READ;
                  r_n_avg     <= n_avg;
                  r_last_addr <= last_addr;
                  r_rd_addr   <= '0;
               end
            end
            S_READ: begin
               if (w_issue) begin
                  // Wraps to 0 after the top address; never issued from there.
                  r_rd_addr <= r_rd_addr + 1'b1;
                  if (w_is_last_rd) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (w_pop && w_head_last) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // BRAM read pipeline tracking: marks which cycle returns a requested word.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_pv    <= '0;
         r_plast <= '0;
      end else begin
         r_pv[0]    <= w_issue;
         r_plast[0] <= w_issue && w_is_last_rd;
         for (int i = 1; i < BRAM_LATENCY; i++) begin
            r_pv[i]    <= r_pv[i-1];
            r_plast[i] <= r_plast[i-1];
         end
      end
   end

   // Output FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) begin
            r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Output FIFO storage; contents are masked by occupancy so need no reset.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_fifo_data[r_wptr] <= bram_rdata;
         r_fifo_last[r_wptr] <= w_wr_last;
      end
   end

endmodule

// File: tb/tb_averager_readout.sv
`timescale 1ns/1ps
module tb_averager_readout;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int ecount = 0;
   always @(posedge clk) ecount <= ecount + 1;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int lat, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s lat=%0d actual=0x%0h required=0x%0h t=%0t", name, lat, act, exp, $time);
      end
   endtask

   // One independent DUT + BRAM model + scoreboard per legal BRAM latency.
   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int L = g + 1;

      logic        resetn, start, bram_en, m_axis_tvalid, m_axis_tready, m_axis_tlast;
      logic        busy, done, overrun;
      logic [6:0]  last_addr, bram_addr;
      logic [9:0]  n_avg, n_avg_latched;
      logic [31:0] bram_rdata, m_axis_tdata;
      logic [31:0] mem  [128];
      logic [31:0] pipe [L];
      logic [32:0] q [$];
      bit          rnd;
      bit          fin;
      int          t0;
      logic [6:0]  exp_last;
      logic [9:0]  exp_navg;

      averager_readout #(
         .ADDR_WIDTH(7), .DATA_WIDTH(32), .N_AVG_WIDTH(10), .BRAM_LATENCY(L)
      ) dut (
         .clk(clk), .resetn(resetn), .start(start), .last_addr(last_addr), .n_avg(n_avg),
         .bram_en(bram_en), .bram_addr(bram_addr), .bram_rdata(bram_rdata),
         .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
         .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
         .n_avg_latched(n_avg_latched), .busy(busy), .done(done), .overrun(overrun)
      );

      // BRAM model: data valid L cycles after the enable cycle, garbage otherwise.
      always @(posedge clk) begin
         pipe[0] <= bram_en ? mem[bram_addr] : $urandom;
         for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign bram_rdata = pipe[L-1];

      initial begin
         m_axis_tready = 1'b1;
         forever begin
            @(posedge clk); #1;
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end

      // Monitor: pops the scoreboard on every handshake.
      int          issued = 0;
      int          popped = 0;
      bit          prev_stall = 0;
      bit          prev_done = 0;
      logic [31:0] prev_data;
      logic [32:0] e;
      always @(negedge clk) begin
         if (!resetn) begin
            issued = 0; popped = 0; prev_stall = 0; prev_done = 0;
         end else begin
            if (prev_stall) begin
               chk("stall_tvalid", L, m_axis_tvalid, 1);
               chk("stall_tdata", L, m_axis_tdata, prev_data);
            end
            if (prev_done) chk("done_one_cycle", L, done, 0);
            if (bram_en) issued++;
            if (m_axis_tvalid && m_axis_tready) begin
               popped++;
               if (q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_word lat=%0d actual=0x%0h required=none t=%0t", L, m_axis_tdata, $time);
               end else begin
                  e = q.pop_front();
                  chk("tdata", L, m_axis_tdata, e[31:0]);
                  chk("tlast", L, m_axis_tlast, e[32]);
               end
            end
            checks++;
            if (issued - popped > L + 2) begin
               failures++;
               $display("FAIL outstanding lat=%0d actual=%0d required<=%0d t=%0t", L, issued - popped, L + 2, $time);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_done  = done;
         end
      end

      task automatic chk_zero(input string tag);
         chk({tag, "_bram_en"}, L, bram_en, 0);
         chk({tag, "_bram_addr"}, L, bram_addr, 0);
         chk({tag, "_tvalid"}, L, m_axis_tvalid, 0);
         chk({tag, "_tlast"}, L, m_axis_tlast, 0);
         chk({tag, "_tdata"}, L, m_axis_tdata, 0);
         chk({tag, "_busy"}, L, busy, 0);
         chk({tag, "_done"}, L, done, 0);
         chk({tag, "_overrun"}, L, overrun, 0);
         chk({tag, "_n_avg_latched"}, L, n_avg_latched, 0);
      endtask

      task automatic idle(input int n);
         repeat (n) begin @(posedge clk); #1; end
      endtask

      // Issue start and push the whole expected frame into the scoreboard.
      task automatic kick(input logic [6:0] la, input logic [9:0] na);
         start = 1'b1; last_addr = la; n_avg = na;
         exp_last = la; exp_navg = na;
         t0 = ecount + 1;
         for (int a = 0; a <= int'(la); a++) q.push_back({(a == int'(la)), mem[a]});
      endtask

      task automatic wait_frame(input bit timing, input int ovr_at, input int rst_at);
         int cyc;
         bit seen_v;
         bit fin_f;
         seen_v = 0; fin_f = 0;
         for (int n = 0; n < 3000 && !fin_f; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc = ecount - t0 + 1;
            if (rst_at > 0 && cyc == rst_at + 1) begin
               chk_zero("mid_reset");
               resetn = 1'b1;
               fin_f = 1;
            end else begin
               chk("n_avg_latched", L, n_avg_latched, exp_navg);
               if (cyc == 1) begin
                  chk("busy_c1", L, busy, 1);
                  chk("bram_en_c1", L, bram_en, 1);
                  chk("bram_addr_c1", L, bram_addr, 0);
               end
               if (m_axis_tvalid && !seen_v) begin
                  seen_v = 1;
                  chk("first_tvalid_cycle", L, cyc, 2 + L);
               end
               if (cyc == ovr_at) begin
                  chk("overrun_before", L, overrun, 0);
                  start = 1'b1; last_addr = ~exp_last; n_avg = ~exp_navg;
               end
               if (ovr_at > 0 && cyc == ovr_at + 1) chk("overrun_set", L, overrun, 1);
               if (cyc == rst_at) begin
                  resetn = 1'b0;
                  q.delete();
               end else if (done) begin
                  chk("busy_at_done", L, busy, 0);
                  if (timing) chk("done_cycle", L, cyc, 3 + L + int'(exp_last));
                  fin_f = 1;
               end
            end
         end
         if (!fin_f) begin
            checks++; failures++;
            $display("FAIL frame_timeout lat=%0d actual=no_done required=done t=%0t", L, $time);
         end
      endtask

      initial begin
         resetn = 1'b0; start = 1'b0; last_addr = '0; n_avg = '0; rnd = 0; t0 = 0;
         for (int a = 0; a < 128; a++) mem[a] = 32'(a + 100);
         idle(3);
         chk_zero("reset");
         resetn = 1'b1;
         idle(2);

         kick(7'd15, 10'($urandom)); wait_frame(1, -1, -1);

         rnd = 1; idle(2);
         kick(7'd15, 10'($urandom)); wait_frame(0, -1, -1);

         rnd = 0; idle(2);
         kick(7'd0, 10'($urandom)); wait_frame(1, -1, -1);

         idle(2);
         kick(7'd15, 10'($urandom)); wait_frame(1, 6, -1);
         chk("overrun_sticky", L, overrun, 1);
         kick(7'd5, 10'($urandom)); wait_frame(1, -1, -1);

         idle(2);
         kick(7'd15, 10'($urandom)); wait_frame(0, -1, 8);
         for (int a = 0; a < 128; a++) mem[a] = $urandom;
         rnd = 1; idle(2);
         kick(7'($urandom_range(0, 127)), 10'($urandom)); wait_frame(0, -1, -1);

         rnd = 0; idle(2);
         kick(7'd127, 10'd513); wait_frame(1, -1, -1);
         chk("n_avg_513", L, n_avg_latched, 513);

         rnd = 1;
         for (int f = 0; f < 4; f++) begin
            for (int a = 0; a < 128; a++) mem[a] = $urandom;
            idle(2);
            kick((f == 0) ? 7'd127 : 7'($urandom_range(0, 127)), 10'($urandom));
            wait_frame(0, -1, -1);
         end

         idle(5);
         chk("queue_empty", L, q.size(), 0);
         fin = 1;
      end
   end

   initial begin
      int guard;
      guard = 0;
      while (!(gi[0].fin && gi[1].fin && gi[2].fin) && guard < 80000) begin
         @(posedge clk);
         guard++;
      end
      if (!(gi[0].fin && gi[1].fin && gi[2].fin)) begin
         failures++;
         $display("FAIL global_timeout actual=unfinished required=finished t=%0t", $time);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
